uart_debug_cmd: RTL and testbench
=================================

# uart_debug_cmd

Serial command receiver for the debug UART: the input counterpart of the status printer. It deserialises 8N1 bytes from a host terminal on `rx_pin` and parses ASCII register commands (`Waa=dddd`, `Raa`). It presents each valid command on a ready/valid port to the debug register file and counts malformed input. It sits in the 27 MHz domain beside the debug transmitter.

## Interface
- `CLK_FRE`, 27, clock frequency in MHz
- `BAUD_RATE`, 115200, line rate; derived `DIV = CLK_FRE*1000000/BAUD_RATE` (truncated, 234 at defaults), `HALF = DIV/2` (117)

- `clk`  in  1  system clock, 27 MHz
- `rst_n`  in  1  asynchronous active-low reset
- `rx_pin`  in  1  asynchronous serial input, idle high
- `cmd_valid`  out  1  command pending
- `cmd_ready`  in  1  consumer accepts the command when high with `cmd_valid`
- `cmd_write`  out  1  1 = write, 0 = read
- `cmd_addr`  out  8  register address
- `cmd_data`  out  16  write data; 0 for reads
- `err_pulse`  out  1  one-cycle pulse per detected error
- `err_count`  out  8  saturating error counter (stops at 255)

## Operation
- Reset: all outputs 0. Synchroniser flops are 1. Both FSMs are idle.
- `rx_pin` passes through a 2-flop synchroniser. All logic uses the synchronised value.
- Byte FSM states are R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI.
  - R_IDLE: a low level moves to R_START and clears the counter.
  - R_START: sample at count `HALF-1`. Low moves to R_DATA. High is a glitch: return to R_IDLE with no error.
  - R_DATA: sample every `DIV` cycles, 8 bits, LSB first.
  - R_STOP: sample `DIV` cycles after bit 7. High produces an internal one-cycle `byte_stb` and returns to R_IDLE. Low is a framing error: `err_pulse`, the parser is forced to P_DISCARD, and the FSM moves to R_WAITHI.
  - R_WAITHI: return to R_IDLE when the line is high.
- Parser states are P_IDLE, P_ADDR, P_EQ, P_DATA, P_EOL, P_ISSUE, P_DISCARD. The parser consumes only on `byte_stb`.
  - P_IDLE: `W` sets write and `R` sets read; either clears addr/data and moves to P_ADDR. CR, LF and space are ignored. Any other byte is an error and moves to P_DISCARD.
  - P_ADDR: exactly 2 hex digits (`0-9`, `A-F`), shifted in MSB-first. After the second digit, write goes to P_EQ and read goes to P_EOL.
  - P_EQ: `=` moves to P_DATA.
  - P_DATA: exactly 4 hex digits, then P_EOL.
  - P_EOL: CR or LF latches the outputs and moves to P_ISSUE.
  - Any unexpected byte in P_ADDR, P_EQ, P_DATA or P_EOL: `err_pulse`, then P_DISCARD.
  - P_DISCARD: CR or LF returns to P_IDLE with no error. Other bytes are dropped silently.
  - P_ISSUE: `cmd_valid`=1 with `cmd_write`, `cmd_addr` and `cmd_data` stable. On `cmd_valid && cmd_ready` go to P_IDLE; `cmd_valid` is 0 next cycle.
  - Bytes arriving in P_ISSUE are dropped. CR, LF and space are dropped silently (this allows CRLF). Any other byte gives `err_pulse`. A framing error in P_ISSUE counts but does not cancel the pending command.
- `err_count` increments on each `err_pulse` and saturates at 255. It is cleared only by reset.
- The output fields hold their last values after the handshake.

## Timing
- Synchroniser latency is 2 cycles.
- Start-bit sample: 117 cycles after R_START entry. Bit k sample: 117+234·(k+1). Stop sample: 2223 cycles after R_START entry (defaults).
- `byte_stb` fires on the stop-sample edge. The parser state updates the next edge.
- `cmd_valid` rises 1 cycle after the terminator's `byte_stb`.
- `err_pulse` fires 1 cycle after the offending `byte_stb`, or on the stop-sample edge for framing errors.
- Back-to-back bytes (stop bit immediately followed by start bit) must be received without loss.
- Error and handshake in the same cycle: both take effect.
- Asynchronous reset mid-frame or mid-command: immediate return to reset values. The partial command is discarded.

## Configuration
- `UART_CMD_LOWERCASE_EN`
  - Defined: `w`, `r` and `a-f` are accepted as equivalents of `W`, `R` and `A-F`.
  - Undefined: lowercase bytes are errors in every state where they would otherwise be parsed.

## Test plan
- Send `W1A=BEEF\r` at 115200 with `cmd_ready`=1 → exactly one `cmd_valid` cycle with write=1, addr=0x1A, data=0xBEEF; `err_count`=0.
- Send `R05\r\n` with `cmd_ready`=0 for 5000 cycles after `cmd_valid` rises → `cmd_valid` held with write=0, addr=0x05, data=0x0000. The LF causes no error. `cmd_valid` drops 1 cycle after `cmd_ready`=1.
- Send `W1G=0000\rR01\n` → one `err_pulse` at `G`, no write command, then a read of addr 0x01; `err_count`=1.
- Send a byte with a low stop bit mid-command, then `W02=0003\r` → `err_count`=1, no command from the corrupted line, then a valid write of addr 0x02, data 0x0003. Separately, a 54-cycle low glitch on `rx_pin` → no byte, no error.
- Send `w1a=beef\r` → with the macro: write to addr 0x1A, data 0xBEEF. Without the macro: `err_count`=1 and no command.
- Assert reset 1000 cycles into the `R` of `R10\r`, release, then send `R11\r` → only a read of addr 0x11 issued; `err_count`=0.

Source files
------------

// File: rtl/uart_debug_cmd.sv
// Debug UART command receiver: 8N1 deserialiser plus an ASCII "Waa=dddd" / "Raa" parser.
// Optional UART_CMD_LOWERCASE_EN accepts lowercase command letters and hex digits.
module uart_debug_cmd #(
  parameter int unsigned CLK_FRE   = 27,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_pin,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_write,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        err_pulse,
  output logic [7:0]  err_count
);

  localparam int unsigned DIV  = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV + 1);

  localparam logic [7:0] ChCr = 8'h0d;
  localparam logic [7:0] ChLf = 8'h0a;
  localparam logic [7:0] ChSp = 8'h20;
  localparam logic [7:0] ChEq = 8'h3d;

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI} rx_state_e;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_EQ, P_DATA, P_EOL, P_ISSUE, P_DISCARD} p_state_e;

  // {valid, nibble}
  function automatic logic [4:0] hex_dec(input logic [7:0] b);
    logic [4:0] r;
    r = 5'b0;
    if (b >= 8'h30 && b <= 8'h39) r = {1'b1, b[3:0]};
    else if (b >= 8'h41 && b <= 8'h46) r = {1'b1, b[3:0] + 4'd9};
`ifdef UART_CMD_LOWERCASE_EN
    else if (b >= 8'h61 && b <= 8'h66) r = {1'b1, b[3:0] + 4'd9};
`endif
    return r;
  endfunction

  // {valid, write}
  function automatic logic [1:0] cmd_dec(input logic [7:0] b);
    logic [1:0] r;
    r = 2'b00;
    if (b == 8'h57) r = 2'b11;
    else if (b == 8'h52) r = 2'b10;
`ifdef UART_CMD_LOWERCASE_EN
    else if (b == 8'h77) r = 2'b11;
    else if (b == 8'h72) r = 2'b10;
`endif
    return r;
  endfunction

  logic sync1_q, sync2_q, rx_s;
  assign rx_s = sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_pin;
      sync2_q <= sync1_q;
    end
  end

  // Byte receiver
  rx_state_e     rs_q, rs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    byte_q, byte_d;
  logic          stb_q, stb_d;
  logic          ferr;

  always_comb begin
    rs_d   = rs_q;
    cnt_d  = cnt_q + 1'b1;
    bit_d  = bit_q;
    sh_d   = sh_q;
    byte_d = byte_q;
    stb_d  = 1'b0;
    ferr   = 1'b0;
    unique case (rs_q)
      R_IDLE: begin
        cnt_d = '0;
        if (!rx_s) rs_d = R_START;
      end
      R_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          bit_d = 3'd0;
          rs_d  = rx_s ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) rs_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d = '0;
          if (rx_s) begin
            stb_d  = 1'b1;
            byte_d = sh_q;
            rs_d   = R_IDLE;
          end else begin
            ferr = 1'b1;
            rs_d = R_WAITHI;
          end
        end
      end
      R_WAITHI: begin
        cnt_d = '0;
        if (rx_s) rs_d = R_IDLE;
      end
      default: rs_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q   <= R_IDLE;
      cnt_q  <= '0;
      bit_q  <= 3'd0;
      sh_q   <= 8'h00;
      byte_q <= 8'h00;
      stb_q  <= 1'b0;
    end else begin
      rs_q   <= rs_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      byte_q <= byte_d;
      stb_q  <= stb_d;
    end
  end

  // Command parser
  p_state_e    ps_q, ps_d;
  logic        wr_q, wr_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  dcnt_q, dcnt_d;
  logic        ow_q, ow_d;
  logic [7:0]  oa_q, oa_d;
  logic [15:0] od_q, od_d;
  logic        perr;
  logic        err_q;
  logic [7:0]  ecnt_q;
  logic [4:0]  hx;
  logic [1:0]  cl;
  logic        eol, blank;

  assign hx    = hex_dec(byte_q);
  assign cl    = cmd_dec(byte_q);
  assign eol   = (byte_q == ChCr) || (byte_q == ChLf);
  assign blank = eol || (byte_q == ChSp);

  always_comb begin
    ps_d   = ps_q;
    wr_d   = wr_q;
    addr_d = addr_q;
    data_d = data_q;
    dcnt_d = dcnt_q;
    ow_d   = ow_q;
    oa_d   = oa_q;
    od_d   = od_q;
    perr   = 1'b0;
    if (stb_q) begin
      unique case (ps_q)
        P_IDLE: begin
          if (cl[1]) begin
            wr_d   = cl[0];
            addr_d = 8'h00;
            data_d = 16'h0000;
            dcnt_d = 2'd0;
            ps_d   = P_ADDR;
          end else if (!blank) begin
            perr = 1'b1;
            ps_d = P_DISCARD;
          end
        end
        P_ADDR: begin
          if (hx[4]) begin
            addr_d = {addr_q[3:0], hx[3:0]};
            dcnt_d = dcnt_q + 2'd1;
            if (dcnt_q == 2'd1) begin
              dcnt_d = 2'd0;
              ps_d   = wr_q ? P_EQ : P_EOL;
            end
          end else begin
            perr = 1'b1;
            ps_d = P_DISCARD;
          end
        end
        P_EQ: begin
          if (byte_q == ChEq) begin
            ps_d = P_DATA;
          end else begin
            perr = 1'b1;
            ps_d = P_DISCARD;
          end
        end
        P_DATA: begin
          if (hx[4]) begin
            data_d = {data_q[11:0], hx[3:0]};
            dcnt_d = dcnt_q + 2'd1;
            if (dcnt_q == 2'd3) ps_d = P_EOL;
          end else begin
            perr = 1'b1;
            ps_d = P_DISCARD;
          end
        end
        P_EOL: begin
          if (eol) begin
            ow_d = wr_q;
            oa_d = addr_q;
            od_d = data_q;
            ps_d = P_ISSUE;
          end else begin
            perr = 1'b1;
            ps_d = P_DISCARD;
          end
        end
        P_ISSUE: begin
          // CRLF tails are expected; anything else is flagged but the command stays pending
          if (!blank) perr = 1'b1;
        end
        P_DISCARD: begin
          if (eol) ps_d = P_IDLE;
        end
        default: ps_d = P_IDLE;
      endcase
    end
    if (ps_q == P_ISSUE && cmd_ready) ps_d = P_IDLE;
    if (ferr && ps_q != P_ISSUE) ps_d = P_DISCARD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q   <= P_IDLE;
      wr_q   <= 1'b0;
      addr_q <= 8'h00;
      data_q <= 16'h0000;
      dcnt_q <= 2'd0;
      ow_q   <= 1'b0;
      oa_q   <= 8'h00;
      od_q   <= 16'h0000;
      err_q  <= 1'b0;
      ecnt_q <= 8'h00;
    end else begin
      ps_q   <= ps_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      dcnt_q <= dcnt_d;
      ow_q   <= ow_d;
      oa_q   <= oa_d;
      od_q   <= od_d;
      err_q  <= ferr | perr;
      if ((ferr | perr) && ecnt_q != 8'hff) ecnt_q <= ecnt_q + 8'd1;
    end
  end

  assign cmd_valid = (ps_q == P_ISSUE);
  assign cmd_write = ow_q;
  assign cmd_addr  = oa_q;
  assign cmd_data  = od_q;
  assign err_pulse = err_q;
  assign err_count = ecnt_q;

endmodule

// File: tb/tb_uart_debug_cmd.sv
// Directed bench for uart_debug_cmd: serial command strings in, handshakes and errors checked.
// A faster line rate keeps the run short; bit timing scales with the DUT's own divider.
module tb_uart_debug_cmd;

  localparam int unsigned CLK_FRE = 27;
  localparam int unsigned BAUD    = 460800;
  localparam int unsigned DIV     = CLK_FRE * 1000000 / BAUD;
  localparam int unsigned HALF    = DIV / 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_pin = 1'b1;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid, cmd_write, err_pulse;
  logic [7:0]  cmd_addr, err_count;
  logic [15:0] cmd_data;

  uart_debug_cmd #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_pin    (rx_pin),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_hs = 0, n_vcyc = 0, n_ep = 0;
  int hs0, ep0, vc0;
  logic        last_w = 1'b0;
  logic [7:0]  last_a = 8'h00;
  logic [15:0] last_d = 16'h0000;

  always @(negedge clk) begin
    if (cmd_valid) n_vcyc <= n_vcyc + 1;
    if (cmd_valid && cmd_ready) begin
      n_hs   <= n_hs + 1;
      last_w <= cmd_write;
      last_a <= cmd_addr;
      last_d <= cmd_data;
    end
    if (err_pulse) n_ep <= n_ep + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    hs0 = n_hs;
    ep0 = n_ep;
    vc0 = n_vcyc;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_pin = 1'b0;
    cyc(DIV);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      cyc(DIV);
    end
    rx_pin = stop;
    cyc(DIV);
    rx_pin = 1'b1;
    if (!stop) cyc(DIV);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1);
  endtask

  initial begin
    logic [9:0] fr;

    cyc(5);
    check("rst_valid", cmd_valid, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_count", err_count, 0);
    check("rst_addr", cmd_addr, 0);
    check("rst_data", cmd_data, 0);
    rst_n = 1'b1;
    cyc(5);

    // Plain write, consumer always ready
    cmd_ready = 1'b1;
    snap();
    send_str("W1A=BEEF\015");
    cyc(5);
    check("w1a_hs", n_hs - hs0, 1);
    check("w1a_vcyc", n_vcyc - vc0, 1);
    check("w1a_write", last_w, 1);
    check("w1a_addr", last_a, 8'h1a);
    check("w1a_data", last_d, 16'hbeef);
    check("w1a_errcnt", err_count, 0);
    check("w1a_valid_low", cmd_valid, 0);

    // Read held under backpressure, LF tail accepted silently
    cmd_ready = 1'b0;
    snap();
    send_str("R05\015");
    check("r05_valid_rise", cmd_valid, 1);
    send_str("\n");
    cyc(5000 - 10 * DIV);
    check("r05_valid_held", cmd_valid, 1);
    check("r05_write", cmd_write, 0);
    check("r05_addr", cmd_addr, 8'h05);
    check("r05_data", cmd_data, 16'h0000);
    check("r05_no_err", n_ep - ep0, 0);
    cmd_ready = 1'b1;
    cyc(1);
    check("r05_valid_drop", cmd_valid, 0);
    cyc(1);
    check("r05_hs", n_hs - hs0, 1);
    check("r05_hold_after", cmd_addr, 8'h05);

    // Bad hex digit discards the line, next line is a read
    snap();
    send_str("W1G=0000\015R01\n");
    cyc(5);
    check("bad_hex_ep", n_ep - ep0, 1);
    check("bad_hex_hs", n_hs - hs0, 1);
    check("bad_hex_write", last_w, 0);
    check("bad_hex_addr", last_a, 8'h01);
    check("bad_hex_errcnt", err_count, 1);

    // Framing error mid-command
    snap();
    send_str("W0");
    send_frame(8'h33, 1'b0);
    send_str("\015W02=0003\015");
    cyc(5);
    check("frame_ep", n_ep - ep0, 1);
    check("frame_errcnt", err_count, 2);
    check("frame_hs", n_hs - hs0, 1);
    check("frame_write", last_w, 1);
    check("frame_addr", last_a, 8'h02);
    check("frame_data", last_d, 16'h0003);

    // Short low glitch inside a command must not produce a byte
    snap();
    send_str("R0");
    rx_pin = 1'b0;
    cyc(HALF - 5);
    rx_pin = 1'b1;
    cyc(10 * DIV);
    send_str("3\015");
    cyc(5);
    check("glitch_ep", n_ep - ep0, 0);
    check("glitch_hs", n_hs - hs0, 1);
    check("glitch_addr", last_a, 8'h03);
    check("glitch_write", last_w, 0);

    // Lowercase command
    snap();
    send_str("w1a=beef\015");
    cyc(5);
`ifdef UART_CMD_LOWERCASE_EN
    check("lc_hs", n_hs - hs0, 1);
    check("lc_addr", last_a, 8'h1a);
    check("lc_data", last_d, 16'hbeef);
    check("lc_errcnt", err_count, 2);
`else
    check("lc_hs", n_hs - hs0, 0);
    check("lc_ep", n_ep - ep0, 1);
    check("lc_errcnt", err_count, 3);
`endif

    // Reset in the middle of the 'R' of "R10"
    fr = {1'b1, 8'h52, 1'b0};
    for (int c = 0; c < 4 * DIV + DIV / 4; c++) begin
      rx_pin = fr[c / DIV];
      cyc(1);
    end
    rst_n  = 1'b0;
    rx_pin = 1'b1;
    #1;
    check("mid_rst_errcnt", err_count, 0);
    check("mid_rst_valid", cmd_valid, 0);
    check("mid_rst_addr", cmd_addr, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2 * DIV);
    snap();
    send_str("R11\015");
    cyc(5);
    check("post_rst_hs", n_hs - hs0, 1);
    check("post_rst_write", last_w, 0);
    check("post_rst_addr", last_a, 8'h11);
    check("post_rst_ep", n_ep - ep0, 0);
    check("post_rst_errcnt", err_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
